// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load unit,
// with a registered write stage and a per-register busy scoreboard for hazard checks.
module regfile_write_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_addr,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                rsv_valid,
    input  logic [ADDR_W-1:0]   rsv_addr,
    input  logic [ADDR_W-1:0]   chk_addr1,
    input  logic [ADDR_W-1:0]   chk_addr2,
    output logic                chk_busy1,
    output logic                chk_busy2,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                waw_err,
    output logic                RegWrite,
    output logic [ADDR_W-1:0]   WriteReg,
    output logic [DATA_W-1:0]   WriteData
);

    // prio state | meaning
    // PRIO_ALU   | ALU wins when both requesters are valid
    // PRIO_MEM   | load unit wins when both requesters are valid
    typedef enum logic {PRIO_ALU = 1'b0, PRIO_MEM = 1'b1} prio_t;

    prio_t                prio;
    logic                 xfer;
    logic [ADDR_W-1:0]    commit_addr;
    logic [DATA_W-1:0]    commit_data;
    logic [NUM_REGS-1:0]  busy_next;
    logic                 waw_next;

    assign alu_ready   = alu_valid && (!mem_valid || prio == PRIO_ALU);
    assign mem_ready   = mem_valid && (!alu_valid || prio == PRIO_MEM);
    assign xfer        = alu_ready || mem_ready;
    assign commit_addr = alu_ready ? alu_addr : mem_addr;
    assign commit_data = alu_ready ? alu_data : mem_data;

    assign chk_busy1 = busy_vec[chk_addr1];
    assign chk_busy2 = busy_vec[chk_addr2];

    // Reservation is applied after the commit clear so a new producer wins a same-edge collision.
    always_comb begin
        busy_next = busy_vec;
        if (xfer)
            busy_next[commit_addr] = 1'b0;
        if (rsv_valid)
            busy_next[rsv_addr] = 1'b1;
        waw_next = rsv_valid && busy_vec[rsv_addr] && !(xfer && commit_addr == rsv_addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio      <= PRIO_ALU;
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            busy_vec  <= '0;
            waw_err   <= 1'b0;
        end else begin
            if (alu_ready)
                prio <= PRIO_MEM;
            else if (mem_ready)
                prio <= PRIO_ALU;
            RegWrite <= xfer;
            if (xfer) begin
                WriteReg  <= commit_addr;
                WriteData <= commit_data;
            end
            busy_vec <= busy_next;
            waw_err  <= waw_next;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: per-cycle vector table plus a reset sequence.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid, mem_valid, rsv_valid;
    logic        alu_ready, mem_ready;
    logic [3:0]  alu_addr, mem_addr, rsv_addr, chk_addr1, chk_addr2;
    logic [15:0] alu_data, mem_data;
    logic        chk_busy1, chk_busy2, waw_err, RegWrite;
    logic [15:0] busy_vec;
    logic [3:0]  WriteReg;
    logic [15:0] WriteData;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .busy_vec(busy_vec), .waw_err(waw_err),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int av, aa, ad, mv, ma, md, rv, ra, c1, c2;
        int ar, mr, rw, wr, wd, busy, waw, cb1, cb2;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input int idx, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, actual, expected);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        rsv_valid = 0; rsv_addr = 0;
        chk_addr1 = 0; chk_addr2 = 0;
    endtask

    initial begin
        //          av aa ad       mv ma md       rv ra c1 c2   ar mr rw wr wd       busy    waw cb1 cb2
        vecs[0]  = '{0, 0, 0,      0, 0, 0,       0, 0, 0, 0,   0, 0, 0, 0, 0,       0,      0, 0, 0};
        vecs[1]  = '{1, 3, 'hBEEF, 0, 0, 0,       0, 0, 0, 0,   1, 0, 0, 0, 0,       0,      0, 0, 0};
        vecs[2]  = '{1, 3, 'hBEEF, 0, 0, 0,       0, 0, 0, 0,   1, 0, 1, 3, 'hBEEF,  0,      0, 0, 0};
        vecs[3]  = '{1, 3, 'hBEEF, 0, 0, 0,       0, 0, 0, 0,   1, 0, 1, 3, 'hBEEF,  0,      0, 0, 0};
        vecs[4]  = '{0, 0, 0,      0, 0, 0,       0, 0, 0, 0,   0, 0, 1, 3, 'hBEEF,  0,      0, 0, 0};
        vecs[5]  = '{0, 0, 0,      0, 0, 0,       0, 0, 0, 0,   0, 0, 0, 3, 'hBEEF,  0,      0, 0, 0};
        vecs[6]  = '{0, 0, 0,      1, 4, 'h4444,  0, 0, 0, 0,   0, 1, 0, 3, 'hBEEF,  0,      0, 0, 0};
        vecs[7]  = '{1, 1, 'h1111, 1, 2, 'h2222,  0, 0, 0, 0,   1, 0, 1, 4, 'h4444,  0,      0, 0, 0};
        vecs[8]  = '{1, 1, 'h1111, 1, 2, 'h2222,  0, 0, 0, 0,   0, 1, 1, 1, 'h1111,  0,      0, 0, 0};
        vecs[9]  = '{1, 1, 'h1111, 1, 2, 'h2222,  0, 0, 0, 0,   1, 0, 1, 2, 'h2222,  0,      0, 0, 0};
        vecs[10] = '{1, 1, 'h1111, 1, 2, 'h2222,  0, 0, 0, 0,   0, 1, 1, 1, 'h1111,  0,      0, 0, 0};
        vecs[11] = '{0, 0, 0,      0, 0, 0,       0, 0, 0, 0,   0, 0, 1, 2, 'h2222,  0,      0, 0, 0};
        vecs[12] = '{0, 0, 0,      0, 0, 0,       0, 0, 0, 0,   0, 0, 0, 2, 'h2222,  0,      0, 0, 0};
        vecs[13] = '{0, 0, 0,      0, 0, 0,       1, 5, 5, 0,   0, 0, 0, 2, 'h2222,  0,      0, 0, 0};
        vecs[14] = '{0, 0, 0,      1, 5, 'h5555,  0, 0, 5, 0,   0, 1, 0, 2, 'h2222,  'h20,   0, 1, 0};
        vecs[15] = '{0, 0, 0,      0, 0, 0,       0, 0, 5, 0,   0, 0, 1, 5, 'h5555,  0,      0, 0, 0};
        vecs[16] = '{0, 0, 0,      0, 0, 0,       1, 7, 0, 0,   0, 0, 0, 5, 'h5555,  0,      0, 0, 0};
        vecs[17] = '{1, 7, 'h7777, 0, 0, 0,       1, 7, 0, 7,   1, 0, 0, 5, 'h5555,  'h80,   0, 0, 1};
        vecs[18] = '{0, 0, 0,      0, 0, 0,       0, 0, 0, 7,   0, 0, 1, 7, 'h7777,  'h80,   0, 0, 1};
        vecs[19] = '{0, 0, 0,      0, 0, 0,       1, 9, 0, 0,   0, 0, 0, 7, 'h7777,  'h80,   0, 0, 0};
        vecs[20] = '{0, 0, 0,      0, 0, 0,       1, 9, 9, 0,   0, 0, 0, 7, 'h7777,  'h280,  0, 1, 0};
        vecs[21] = '{0, 0, 0,      0, 0, 0,       0, 0, 0, 0,   0, 0, 0, 7, 'h7777,  'h280,  1, 0, 0};
        vecs[22] = '{0, 0, 0,      0, 0, 0,       0, 0, 0, 0,   0, 0, 0, 7, 'h7777,  'h280,  0, 0, 0};

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the next rising edge.
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            alu_valid = vecs[i].av[0]; alu_addr = vecs[i].aa[3:0]; alu_data = vecs[i].ad[15:0];
            mem_valid = vecs[i].mv[0]; mem_addr = vecs[i].ma[3:0]; mem_data = vecs[i].md[15:0];
            rsv_valid = vecs[i].rv[0]; rsv_addr = vecs[i].ra[3:0];
            chk_addr1 = vecs[i].c1[3:0]; chk_addr2 = vecs[i].c2[3:0];
            #1;
            check("alu_ready", i, int'(alu_ready), vecs[i].ar);
            check("mem_ready", i, int'(mem_ready), vecs[i].mr);
            check("RegWrite",  i, int'(RegWrite),  vecs[i].rw);
            check("WriteReg",  i, int'(WriteReg),  vecs[i].wr);
            check("WriteData", i, int'(WriteData), vecs[i].wd);
            check("busy_vec",  i, int'(busy_vec),  vecs[i].busy);
            check("waw_err",   i, int'(waw_err),   vecs[i].waw);
            check("chk_busy1", i, int'(chk_busy1), vecs[i].cb1);
            check("chk_busy2", i, int'(chk_busy2), vecs[i].cb2);
        end

        // Mid-stream reset with a write and a WAW pulse outstanding.
        @(negedge clk);
        idle_inputs();
        alu_valid = 1; alu_addr = 6; alu_data = 16'h6666;
        rsv_valid = 1; rsv_addr = 9;
        @(negedge clk);
        idle_inputs();
        #1;
        check("pre_rst_RegWrite", 100, int'(RegWrite), 1);
        check("pre_rst_WriteReg", 100, int'(WriteReg), 6);
        check("pre_rst_waw_err",  100, int'(waw_err),  1);
        check("pre_rst_busy_vec", 100, int'(busy_vec), 'h280);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_RegWrite",  101, int'(RegWrite),  0);
        check("rst_WriteReg",  101, int'(WriteReg),  0);
        check("rst_WriteData", 101, int'(WriteData), 0);
        check("rst_busy_vec",  101, int'(busy_vec),  0);
        check("rst_waw_err",   101, int'(waw_err),   0);
        @(negedge clk);
        rst_n = 1'b1;
        alu_valid = 1; alu_addr = 4'hA; alu_data = 16'hAAAA;
        mem_valid = 1; mem_addr = 4'hB; mem_data = 16'hBBBB;
        #1;
        check("post_rst_alu_ready", 102, int'(alu_ready), 1);
        check("post_rst_mem_ready", 102, int'(mem_ready), 0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("post_rst_RegWrite",  103, int'(RegWrite),  1);
        check("post_rst_WriteReg",  103, int'(WriteReg),  'hA);
        check("post_rst_WriteData", 103, int'(WriteData), 'hAAAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
